// File: rtl/synth_pkg.sv
// Shared constants and envelope state encoding for the synth voice path.
package synth_pkg;

    localparam int LVL_W            = 31;
    localparam int TICK_DIV_DEFAULT = 1042;

    localparam logic [LVL_W-1:0] ENV_MAX = 31'h4000_0000;

    typedef enum logic [2:0] {
        ENV_IDLE    = 3'd0,
        ENV_ATTACK  = 3'd1,
        ENV_DECAY   = 3'd2,
        ENV_SUSTAIN = 3'd3,
        ENV_RELEASE = 3'd4
    } env_state_t;

    function automatic logic [LVL_W-1:0] min_lvl(input logic [LVL_W-1:0] a,
                                                 input logic [LVL_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/adsr_envelope_sequencer_if.sv
// Voice bus between the keyboard/register side, the ALU wave source and the envelope block.
interface adsr_envelope_sequencer_if;
    import synth_pkg::*;

    // No valid/ready here: every input is a level, control inputs are sampled only on
    // env_tick cycles and wave_in is sampled every cycle.
    logic                    note_in;
    logic [3:0]              note;
    logic [LVL_W-1:0]        amplitude;
    logic [LVL_W-1:0]        attack;
    logic [LVL_W-1:0]        decay;
    logic [LVL_W-1:0]        sustain;
    logic [LVL_W-1:0]        rel;
    logic signed [31:0]      wave_in;
    logic signed [31:0]      wave_out;
    logic [LVL_W-1:0]        env_level;
    logic [2:0]              env_state;
    logic                    env_tick;
    logic                    voice_active;
    logic [3:0]              note_held;

    modport master (
        output note_in, note, amplitude, attack, decay, sustain, rel, wave_in,
        input  wave_out, env_level, env_state, env_tick, voice_active, note_held
    );

    modport slave (
        input  note_in, note, amplitude, attack, decay, sustain, rel, wave_in,
        output wave_out, env_level, env_state, env_tick, voice_active, note_held
    );

endinterface

// File: rtl/sample_tick_gen.sv
// Free-running divider producing a one-cycle envelope update pulse every TICK_DIV clocks.
module sample_tick_gen #(
    parameter int TICK_DIV = 1042
) (
    input  logic clk,
    input  logic reset,
    output logic env_tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset)
            count <= '0;
        else if (count == LAST)
            count <= '0;
        else
            count <= count + CW'(1);
    end

    assign env_tick = (count == LAST);

endmodule

// File: rtl/adsr_envelope_sequencer.sv
// ADSR envelope FSM plus wave scaler; define ADSR_RETRIGGER_EN to restart ATTACK on a new
// note while the key stays held (otherwise note changes are legato).
module adsr_envelope_sequencer
    import synth_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    adsr_envelope_sequencer_if.slave   bus
);

    env_state_t         state, state_nxt;
    logic [LVL_W-1:0]   level, level_nxt;
    logic [3:0]         note_q, note_nxt;
    logic signed [31:0] wave_q;
    logic               tick;
    logic               retrig;

    logic [LVL_W-1:0]   peak, sus, rel_eff;
    logic [LVL_W:0]     att_sum, dec_thr;
    logic signed [63:0] prod;

    sample_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk      (clk),
        .reset    (reset),
        .env_tick (tick)
    );

    assign peak    = min_lvl(bus.amplitude, ENV_MAX);
    assign sus     = min_lvl(bus.sustain, peak);
    assign rel_eff = (bus.rel == '0) ? LVL_W'(1) : bus.rel;
    // One extra bit so level+rate comparisons never wrap.
    assign att_sum = {1'b0, level} + {1'b0, bus.attack};
    assign dec_thr = {1'b0, sus} + {1'b0, bus.decay};

`ifdef ADSR_RETRIGGER_EN
    assign retrig = bus.note_in && (bus.note != note_q) &&
                    ((state == ENV_DECAY) || (state == ENV_SUSTAIN) || (state == ENV_RELEASE));
`else
    assign retrig = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        level_nxt = level;
        note_nxt  = note_q;
        if (tick) begin
            if (bus.note_in)
                note_nxt = bus.note;
            if (retrig) begin
                state_nxt = ENV_ATTACK;
            end else begin
                case (state)
                    ENV_IDLE: begin
                        if (bus.note_in)
                            state_nxt = ENV_ATTACK;
                    end
                    ENV_ATTACK: begin
                        if (!bus.note_in) begin
                            state_nxt = ENV_RELEASE;
                        end else if (att_sum >= {1'b0, peak}) begin
                            level_nxt = peak;
                            state_nxt = ENV_DECAY;
                        end else begin
                            level_nxt = att_sum[LVL_W-1:0];
                        end
                    end
                    ENV_DECAY: begin
                        if (!bus.note_in) begin
                            state_nxt = ENV_RELEASE;
                        end else if (bus.decay != '0) begin
                            if ({1'b0, level} <= dec_thr) begin
                                level_nxt = sus;
                                state_nxt = ENV_SUSTAIN;
                            end else begin
                                level_nxt = level - bus.decay;
                            end
                        end
                    end
                    ENV_SUSTAIN: begin
                        if (!bus.note_in)
                            state_nxt = ENV_RELEASE;
                        else
                            level_nxt = sus;
                    end
                    ENV_RELEASE: begin
                        if (bus.note_in) begin
                            state_nxt = ENV_ATTACK;
                        end else if (level <= rel_eff) begin
                            level_nxt = '0;
                            state_nxt = ENV_IDLE;
                        end else begin
                            level_nxt = level - rel_eff;
                        end
                    end
                    default: begin
                        state_nxt = ENV_IDLE;
                        level_nxt = '0;
                    end
                endcase
            end
        end
    end

    // Level is at most 2^30, so the product shifted by 30 always fits in 32 bits.
    assign prod = $signed(bus.wave_in) * $signed({1'b0, level});

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= ENV_IDLE;
            level  <= '0;
            note_q <= '0;
            wave_q <= '0;
        end else begin
            state  <= state_nxt;
            level  <= level_nxt;
            note_q <= note_nxt;
            wave_q <= 32'(prod >>> 30);
        end
    end

    assign bus.wave_out     = wave_q;
    assign bus.env_level    = level;
    assign bus.env_state    = state;
    assign bus.env_tick     = tick;
    assign bus.voice_active = (state != ENV_IDLE);
    assign bus.note_held    = note_q;

endmodule

// File: tb/tb_adsr_envelope_sequencer.sv
// Bench for adsr_envelope_sequencer with a short tick divider; expectations follow ADSR_RETRIGGER_EN.
module tb_adsr_envelope_sequencer;
    import synth_pkg::*;

    localparam int          TD = 4;
    localparam logic [30:0] M  = 31'h4000_0000;
    localparam logic [30:0] H  = 31'h2000_0000;
    localparam logic [30:0] F  = 31'h7FFF_FFFF;
`ifdef ADSR_RETRIGGER_EN
    localparam bit RT = 1'b1;
`else
    localparam bit RT = 1'b0;
`endif

    typedef struct {
        logic        gate;
        logic [3:0]  note;
        logic [30:0] amp, att, dec, sus, rel;
        logic [2:0]  st;
        logic [30:0] lvl;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    logic [31:0] exp_q[$];
    vec_t vecs[$];

    adsr_envelope_sequencer_if bus ();

    adsr_envelope_sequencer #(.TICK_DIV(TD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic g, input logic [3:0] n,
                                input logic [30:0] a, input logic [30:0] t,
                                input logic [30:0] d, input logic [30:0] s,
                                input logic [30:0] r, input logic [2:0] st,
                                input logic [30:0] l);
        vec_t v;
        v.gate = g; v.note = n; v.amp = a; v.att = t; v.dec = d;
        v.sus = s; v.rel = r; v.st = st; v.lvl = l;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.note_in   = v.gate;
        bus.note      = v.note;
        bus.amplitude = v.amp;
        bus.attack    = v.att;
        bus.decay     = v.dec;
        bus.sustain   = v.sus;
        bus.rel       = v.rel;
    endtask

    task automatic wait_tick();
        int n = 0;
        while (!bus.env_tick && n < 3 * TD) begin
            @(negedge clk);
            n++;
        end
        if (!bus.env_tick) begin
            total++;
            bad++;
            $display("FAIL tick_timeout: got no env_tick within %0d cycles", 3 * TD);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wave_step(input logic signed [31:0] w, input logic [31:0] e);
        bus.wave_in = w;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check("wave_out", bus.wave_out, exp_q.pop_front());
    endtask

    initial begin
        vecs.push_back(mk(1, 3, M, M, 0, 0, H, 3'd1, 0));
        vecs.push_back(mk(1, 3, M, M, 0, 0, H, 3'd2, M));
        vecs.push_back(mk(1, 3, M, M, 0, 0, H, 3'd2, M));
        vecs.push_back(mk(0, 3, M, M, 0, 0, H, 3'd4, M));
        vecs.push_back(mk(0, 3, M, M, 0, 0, H, 3'd4, H));
        vecs.push_back(mk(0, 3, M, M, 0, 0, H, 3'd0, 0));
        vecs.push_back(mk(1, 3, 1000, 300, 100, 600, 250, 3'd1, 0));
        vecs.push_back(mk(1, 3, 1000, 300, 100, 600, 250, 3'd1, 300));
        vecs.push_back(mk(1, 3, 1000, 300, 100, 600, 250, 3'd1, 600));
        vecs.push_back(mk(1, 3, 1000, 300, 100, 600, 250, 3'd1, 900));
        vecs.push_back(mk(1, 3, 1000, 300, 100, 600, 250, 3'd2, 1000));
        vecs.push_back(mk(1, 3, 1000, 300, 100, 600, 250, 3'd2, 900));
        vecs.push_back(mk(1, 3, 1000, 300, 100, 600, 250, 3'd2, 800));
        vecs.push_back(mk(1, 3, 1000, 300, 100, 600, 250, 3'd2, 700));
        vecs.push_back(mk(1, 3, 1000, 300, 100, 600, 250, 3'd3, 600));
        vecs.push_back(mk(1, 3, 1000, 300, 100, 600, 250, 3'd3, 600));
        vecs.push_back(mk(1, 3, 1000, 300, 100, 500, 250, 3'd3, 500));
        vecs.push_back(mk(1, 3, 1000, 300, 100, 5000, 250, 3'd3, 1000));
        vecs.push_back(mk(1, 3, 1000, 300, 100, 600, 250, 3'd3, 600));
        vecs.push_back(mk(1, 5, 1000, 300, 100, 600, 250, RT ? 3'd1 : 3'd3, 600));
        vecs.push_back(mk(0, 5, 1000, 300, 100, 600, 250, 3'd4, 600));
        vecs.push_back(mk(0, 5, 1000, 300, 100, 600, 250, 3'd4, 350));
        vecs.push_back(mk(0, 5, 1000, 300, 100, 600, 250, 3'd4, 100));
        vecs.push_back(mk(0, 5, 1000, 300, 100, 600, 250, 3'd0, 0));
        vecs.push_back(mk(1, 5, 1000, 1500, 0, 600, 0, 3'd1, 0));
        vecs.push_back(mk(1, 5, 1000, 1500, 0, 600, 0, 3'd2, 1000));
        vecs.push_back(mk(1, 5, 1000, 1500, 0, 600, 0, 3'd2, 1000));
        vecs.push_back(mk(0, 5, 1000, 1500, 0, 600, 0, 3'd4, 1000));
        vecs.push_back(mk(0, 5, 1000, 1500, 0, 600, 0, 3'd4, 999));
        vecs.push_back(mk(1, 5, 1000, 1500, 0, 600, 0, 3'd1, 999));
        vecs.push_back(mk(0, 5, 1000, 1500, 0, 600, 0, 3'd4, 999));
        vecs.push_back(mk(0, 5, 1000, 1500, 0, 600, 2000, 3'd0, 0));
        vecs.push_back(mk(1, 5, F, F, 0, 0, F, 3'd1, 0));
        vecs.push_back(mk(1, 5, F, F, 0, 0, F, 3'd2, M));
        vecs.push_back(mk(0, 5, F, F, 0, 0, F, 3'd4, M));
        vecs.push_back(mk(0, 5, F, F, 0, 0, F, 3'd0, 0));
        vecs.push_back(mk(1, 5, 1000, 300, 100, 600, 250, 3'd1, 0));
        vecs.push_back(mk(1, 5, 1000, 300, 100, 600, 250, 3'd1, 300));

        // reset held with the key down
        reset = 1'b0;
        drive(vecs[0]);
        bus.wave_in = 32'sd1234;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state", bus.env_state, 0);
        check("rst_level", bus.env_level, 0);
        check("rst_wave", bus.wave_out, 0);
        check("rst_tick", bus.env_tick, 0);
        check("rst_active", bus.voice_active, 0);
        check("rst_note", bus.note_held, 0);
        bus.wave_in = 0;

        // first tick lands on the 4th clock after reset release
        reset = 1'b1;
        @(posedge clk); #1;
        check("tick_clk1", bus.env_tick, 0);
        @(posedge clk); #1;
        check("tick_clk2", bus.env_tick, 0);
        @(posedge clk); #1;
        check("tick_clk3", bus.env_tick, 1);
        check("tick_clk3_state", bus.env_state, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            wait_tick();
            check($sformatf("v%0d_state", i), bus.env_state, vecs[i].st);
            check($sformatf("v%0d_level", i), bus.env_level, vecs[i].lvl);
            check($sformatf("v%0d_active", i), bus.voice_active, vecs[i].st != 3'd0);
            if (i == 2) begin
                wave_step(32'h8000_0000, 32'h8000_0000);
                wave_step(32'sd1000, 32'd1000);
                bus.wave_in = 0;
            end
            if (i == 4) begin
                wave_step(32'sd1000, 32'd500);
                wave_step(-32'sd1001, 32'hFFFF_FE0B);
                bus.wave_in = 0;
            end
            if (i == 19)
                check("note_latched", bus.note_held, 5);
        end

        // reset in the middle of ATTACK aborts without release
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("abort_state", bus.env_state, 0);
        check("abort_level", bus.env_level, 0);
        check("abort_active", bus.voice_active, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
